instr_mem_loader: RTL

Parametrised dual-read-port instruction memory with a built-in program-load engine. Port I serves the fetch stage. Port D serves data-side loads from the instruction space. A streaming Valid/Ready load channel lets a boot/debug master write a block of words without a CPU store path. Replaces the fixed 4KB wrapper with a generic inferred RAM (true dual-port, synchronous read).

---
 rtl/instr_mem_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: dual-read-port instruction RAM with a streaming program-load engine.
// Port I feeds fetch and port D serves data-side reads. A Valid/Ready channel writes a
// block of words starting at Load_Base and wraps modulo depth.
// Optional macro IMEM_PARITY_EN stores even parity per word and checks it on every read.
`ifndef I_NOP
`define I_NOP 32'h0000_0013
`endif

module instr_mem_loader #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = `I_NOP
) (
    input  logic                  Clock,
    input  logic                  SysReset,
    input  logic                  En_I,
    input  logic [ADDR_WIDTH-1:0] Addr_I,
    output logic [DATA_WIDTH-1:0] Data_I,
    output logic                  Valid_I,
    input  logic                  En_D,
    input  logic [ADDR_WIDTH-1:0] Addr_D,
    output logic [DATA_WIDTH-1:0] Data_D,
    output logic                  Valid_D,
    input  logic                  Load_Start,
    input  logic [ADDR_WIDTH-1:0] Load_Base,
    input  logic [ADDR_WIDTH:0]   Load_Count,
    input  logic                  Load_Valid,
    input  logic [DATA_WIDTH-1:0] Load_Data,
    output logic                  Load_Ready,
    output logic                  Load_Busy,
    output logic                  Load_Done,
    output logic                  ParErr_I,
    output logic                  ParErr_D
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_CNT   = {{ADDR_WIDTH{1'b0}}, 1'b1};
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    logic [MEM_W-1:0]      mem [DEPTH];
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remain;
    logic [ADDR_WIDTH:0]   count_sat;
    logic                  wr_en;
    logic [MEM_W-1:0]      wr_word;
    logic                  rd_ok;

    // Oversized requests are clamped to the full depth.
    assign count_sat = (Load_Count > DEPTH_CNT) ? DEPTH_CNT : Load_Count;
    assign rd_ok     = (state == IDLE);

`ifdef IMEM_PARITY_EN
    assign wr_word = {^Load_Data, Load_Data};
`else
    assign wr_word = Load_Data;
`endif

    // State register
    always_ff @(posedge Clock) begin
        if (SysReset) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic: a zero-length load goes straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Load_Start) state_nxt = (Load_Count == '0) ? DONE : LOAD;
            LOAD: if (wr_en && remain == ONE_CNT) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. Reset blocks the write so an aborted load drops the in-flight word.
    always_comb begin
        Load_Ready = (state == LOAD);
        Load_Busy  = (state == LOAD);
        Load_Done  = (state == DONE);
        wr_en      = (state == LOAD) && Load_Valid && !SysReset;
    end

    // Load pointer and remaining count, captured on an accepted start
    always_ff @(posedge Clock) begin
        if (SysReset) begin
            ptr    <= '0;
            remain <= '0;
        end else if (state == IDLE && Load_Start && Load_Count != '0) begin
            ptr    <= Load_Base;
            remain <= count_sat;
        end else if (wr_en) begin
            ptr    <= ptr + 1'b1;
            remain <= remain - ONE_CNT;
        end
    end

    // RAM write port, shared with the D side; contents survive reset
    always_ff @(posedge Clock) begin
        if (wr_en) mem[ptr] <= wr_word;
    end

    // Fetch port: squashed to NOP while the engine owns the RAM
    always_ff @(posedge Clock) begin
        if (SysReset || !rd_ok) begin
            Data_I  <= NOP_WORD;
            Valid_I <= 1'b0;
        end else if (En_I) begin
            Valid_I <= 1'b1;
`ifdef IMEM_PARITY_EN
            Data_I  <= (^mem[Addr_I]) ? NOP_WORD : mem[Addr_I][DATA_WIDTH-1:0];
`else
            Data_I  <= mem[Addr_I];
`endif
        end else begin
            Valid_I <= 1'b0;
        end
    end

    // Data port: stalls and holds its last word while loading
    always_ff @(posedge Clock) begin
        if (SysReset) begin
            Data_D  <= '0;
            Valid_D <= 1'b0;
        end else if (rd_ok && En_D) begin
            Data_D  <= mem[Addr_D][DATA_WIDTH-1:0];
            Valid_D <= 1'b1;
        end else begin
            Valid_D <= 1'b0;
        end
    end

`ifdef IMEM_PARITY_EN
    // Parity flags are only meaningful alongside the matching Valid pulse
    always_ff @(posedge Clock) begin
        if (SysReset) begin
            ParErr_I <= 1'b0;
            ParErr_D <= 1'b0;
        end else begin
            ParErr_I <= rd_ok && En_I && (^mem[Addr_I]);
            ParErr_D <= rd_ok && En_D && (^mem[Addr_D]);
        end
    end
`else
    assign ParErr_I = 1'b0;
    assign ParErr_D = 1'b0;
`endif

endmodule
